uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync2.sv | 23 ++
 rtl/uart_rx_os.sv | 144 ++++++++++++++
 tb/tb_uart_rx_os.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    localparam int DEFAULT_OVERSAMPLING = 8;
    localparam int DEFAULT_DATA_BITS    = 8;

    // Counter widths must stay at least one bit even for degenerate sizes.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], d};
        end
    end

    assign q = r_sync[1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first payload,
// stop-bit check with frame-error reporting and break (line held low) handling.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W = safe_clog2(OVERSAMPLING);
    localparam int IDX_W = safe_clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLING - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;

    logic                 w_rxd_s;
    logic                 w_sample_en;
    logic [DATA_BITS-1:0] w_shift;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (w_rxd_s)
    );

    assign w_sample_en = (r_state == ST_DATA) && baud_tick && (r_cnt == CNT_FULL);

    // One flop per payload bit; only the bit addressed by r_bit_idx captures on a sample tick.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            logic r_bit;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_bit <= 1'b0;
                end else if (w_sample_en && (r_bit_idx == IDX_W'(gi))) begin
                    r_bit <= w_rxd_s;
                end
            end
            assign w_shift[gi] = r_bit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        if (r_cnt == CNT_HALF) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= w_rxd_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (r_cnt == CNT_FULL) begin
                            r_cnt <= '0;
                            if (r_bit_idx == IDX_LAST) begin
                                r_bit_idx <= '0;
                                r_state   <= ST_STOP;
                            end else begin
                                r_bit_idx <= r_bit_idx + IDX_ONE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (r_cnt == CNT_FULL) begin
                            r_cnt <= '0;
                            if (w_rxd_s) begin
                                r_rx_data  <= w_shift;
                                r_rx_valid <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_WAIT_HIGH;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                // A low stop bit may be a break: ignore the line until it returns high.
                ST_WAIT_HIGH: begin
                    if (w_rxd_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed frame table, glitch/reset/tick-gating sequences, random frames vs. a frame-level model.
module tb_uart_rx_os;

    localparam int OS    = 8;
    localparam int DBITS = 8;

    logic             clk;
    logic             rst_n;
    logic             baud_tick;
    logic             rxd;
    logic [DBITS-1:0] rx_data;
    logic             rx_valid;
    logic             rx_frame_err;
    logic             rx_busy;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic tick_en = 1'b1;
    logic [7:0] obs_q[$];

    uart_rx_os #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clocks, updated on the falling edge.
    initial begin
        int div;
        div = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            baud_tick = tick_en && (div == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: counts pulses and checks pulse shape.
    initial begin
        logic prev_v, prev_e;
        prev_v = 1'b0;
        prev_e = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 || rx_frame_err === 1'b1) begin
                chk("valid_err_exclusive", {31'd0, rx_valid & rx_frame_err}, 32'd0);
                if (rx_valid) begin
                    chk("valid_one_cycle", {31'd0, prev_v}, 32'd0);
                    n_valid++;
                    obs_q.push_back(rx_data);
                end
                if (rx_frame_err) begin
                    chk("err_one_cycle", {31'd0, prev_e}, 32'd0);
                    n_err++;
                end
            end
            prev_v = rx_valid;
            prev_e = rx_frame_err;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic line_for(input logic v, input int ticks);
        rxd = v;
        wait_ticks(ticks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int brk, input int gap);
        line_for(1'b0, OS);
        for (int i = 0; i < DBITS; i++) line_for(d[i], OS);
        line_for(stop, OS);
        if (brk > 0) line_for(1'b0, brk);
        line_for(1'b1, gap);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         brk;
        int         gap;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int v0, e0, waited;
        logic [7:0] pat;
        logic [7:0] model_last;
        logic [7:0] exp_q[$];
        int exp_err_cnt;

        vecs[0] = '{8'hA5, 1'b1, 0,      4, 1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 20*OS,  4, 0, 1, 8'hA5};
        vecs[2] = '{8'h11, 1'b1, 0,      4, 1, 0, 8'h11};
        vecs[3] = '{8'h00, 1'b1, 0,      0, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0,      4, 1, 0, 8'hFF};

        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, rx_frame_err}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(16);

        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].brk, 0);
            if (vecs[i].brk > 0) chk($sformatf("vec%0d_break_busy", i), {31'd0, rx_busy}, 32'd1);
            line_for(1'b1, vecs[i].gap);
            chk($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_err_count", i), n_err - e0, vecs[i].exp_err);
            chk($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            $display("vec %0d: data=0x%02h stop=%0b -> valid=%0d err=%0d rx_data=0x%02h",
                     i, vecs[i].data, vecs[i].stop, n_valid - v0, n_err - e0, rx_data);
        end

        // Short low glitch must be rejected at the mid-start sample.
        v0 = n_valid;
        e0 = n_err;
        line_for(1'b0, 2);
        chk("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        rxd = 1'b1;
        waited = 0;
        while (rx_busy === 1'b1 && waited < 5) begin
            wait_ticks(1);
            waited++;
        end
        chk("glitch_back_idle", {31'd0, rx_busy}, 32'd0);
        wait_ticks(16);
        chk("glitch_no_valid", n_valid - v0, 0);
        chk("glitch_no_err", n_err - e0, 0);
        $display("glitch: busy cleared after %0d ticks, rx_data=0x%02h", waited, rx_data);

        // Asynchronous reset during bit 4 of 0x5A.
        chk("pre_reset_rx_data", {24'd0, rx_data}, 32'hFF);
        pat = 8'h5A;
        v0 = n_valid;
        e0 = n_err;
        line_for(1'b0, OS);
        for (int i = 0; i < 4; i++) line_for(pat[i], OS);
        line_for(pat[4], OS / 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("async_reset_busy", {31'd0, rx_busy}, 32'd0);
        chk("async_reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("async_reset_err", {31'd0, rx_frame_err}, 32'd0);
        repeat (3) @(posedge clk);
        rxd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2 * OS);
        chk("post_reset_no_valid", n_valid - v0, 0);
        chk("post_reset_no_err", n_err - e0, 0);
        send_frame(8'hC3, 1'b1, 0, 4);
        chk("post_reset_valid_count", n_valid - v0, 1);
        chk("post_reset_rx_data", {24'd0, rx_data}, 32'hC3);
        $display("reset: mid-frame abort, then frame 0xC3 -> rx_data=0x%02h", rx_data);

        // Ticks gated off for 100 clocks during bit 3 of 0x96.
        pat = 8'h96;
        v0 = n_valid;
        e0 = n_err;
        line_for(1'b0, OS);
        for (int i = 0; i < 3; i++) line_for(pat[i], OS);
        line_for(pat[3], 3);
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("gated_busy", {31'd0, rx_busy}, 32'd1);
        chk("gated_no_valid", n_valid - v0, 0);
        tick_en = 1'b1;
        wait_ticks(OS - 3);
        for (int i = 4; i < DBITS; i++) line_for(pat[i], OS);
        line_for(1'b1, OS);
        line_for(1'b1, 4);
        chk("gated_valid_count", n_valid - v0, 1);
        chk("gated_err_count", n_err - e0, 0);
        chk("gated_rx_data", {24'd0, rx_data}, 32'h96);
        $display("gating: frame 0x96 with 100-clk tick gap -> rx_data=0x%02h", rx_data);

        // Random frames against a frame-level model.
        model_last = rx_data === 8'h96 ? 8'h96 : 8'h96;
        obs_q.delete();
        exp_err_cnt = 0;
        e0 = n_err;
        for (int f = 0; f < 30; f++) begin
            logic [7:0] d;
            logic       s;
            int         g;
            d = 8'($urandom);
            s = ($urandom_range(0, 4) != 0);
            g = s ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
            if (s) begin
                exp_q.push_back(d);
                model_last = d;
            end else begin
                exp_err_cnt++;
            end
            send_frame(d, s, 0, g);
            $display("rand %0d: data=0x%02h stop=%0b gap=%0d rx_data=0x%02h", f, d, s, g, rx_data);
        end
        wait_ticks(4);
        chk("rand_valid_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand_data_%0d", i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        chk("rand_err_count", n_err - e0, exp_err_cnt);
        chk("rand_final_rx_data", {24'd0, rx_data}, {24'd0, model_last});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
